// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D round-robin scheduler.
package a2d_pkg;

  typedef enum logic [1:0] {SLOT_LFT, SLOT_RGHT, SLOT_STEER, SLOT_BATT} slot_e;

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_e;

  localparam logic [10:0] CMD_PAD = 11'h000;

  function automatic logic [2:0] slot_chnl(
    input slot_e      slot,
    input logic [2:0] ch_lft,
    input logic [2:0] ch_rght,
    input logic [2:0] ch_steer,
    input logic [2:0] ch_batt
  );
    logic [2:0] ch;
    case (slot)
      SLOT_LFT:   ch = ch_lft;
      SLOT_RGHT:  ch = ch_rght;
      SLOT_STEER: ch = ch_steer;
      default:    ch = ch_batt;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/a2d_gap_cntr.sv
// Loadable down-counter timing the idle gap between the command and read transactions.
module a2d_gap_cntr #(
  parameter int unsigned GAP_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  // Loaded with GAP_CYC-1 so the read wrt lands exactly GAP_CYC clocks after the done.
  localparam logic [3:0] LOAD_VAL = 4'(GAP_CYC - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin scheduler sharing the A2D SPI link between four analog sources.
// Define A2D_AVG_EN to make each result register a two-sample running average.
module a2d_rr_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        cnv_cmplt
);

  state_e      state_q, state_d;
  slot_e       rr_q, rr_d;
  logic        pending_q, pending_d;
  logic        wrt_q, wrt_d;
  logic        busy_q, busy_d;
  logic        cnv_q, cnv_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] res_q [4];
  logic [11:0] res_d [4];
  logic [11:0] sample;
  logic        gap_load, gap_dec, gap_expired;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

`ifdef A2D_AVG_EN
  logic [3:0] seeded_q, seeded_d;

  always_comb begin
    sample = rd_data[11:0];
    if (seeded_q[rr_q]) begin
      sample = 12'((13'({1'b0, res_q[rr_q]}) + 13'({1'b0, rd_data[11:0]})) >> 1);
    end
  end
`else
  always_comb begin
    sample = rd_data[11:0];
  end
`endif

  a2d_gap_cntr #(
    .GAP_CYC(GAP_CYC)
  ) u_gap_cntr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (gap_load),
    .dec    (gap_dec),
    .expired(gap_expired)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    pending_d = pending_q;
    wrt_d     = 1'b0;
    busy_d    = busy_q;
    cnv_d     = 1'b0;
    cmd_d     = cmd_q;
    res_d     = res_q;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
`ifdef A2D_AVG_EN
    seeded_d  = seeded_q;
`endif
    // Any request outside IDLE (including one coincident with the final done) waits one-deep.
    if (nxt && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (nxt || pending_q) begin
          cmd_d     = {2'b00, slot_chnl(rr_q, CH_LFT, CH_RGHT, CH_STEER, CH_BATT), CMD_PAD};
          wrt_d     = 1'b1;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        if (done) begin
          gap_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_expired) begin
          wrt_d   = 1'b1;
          state_d = READ;
        end else begin
          gap_dec = 1'b1;
        end
      end
      READ: begin
        if (done) begin
          res_d[rr_q] = sample;
          cnv_d       = 1'b1;
          rr_d        = slot_e'(rr_q + 2'd1);
          busy_d      = 1'b0;
          state_d     = IDLE;
`ifdef A2D_AVG_EN
          seeded_d[rr_q] = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= SLOT_LFT;
      pending_q <= 1'b0;
      wrt_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnv_q     <= 1'b0;
      cmd_q     <= '0;
      res_q     <= '{default: '0};
`ifdef A2D_AVG_EN
      seeded_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      wrt_q     <= wrt_d;
      busy_q    <= busy_d;
      cnv_q     <= cnv_d;
      cmd_q     <= cmd_d;
      res_q     <= res_d;
`ifdef A2D_AVG_EN
      seeded_q  <= seeded_d;
`endif
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign busy      = busy_q;
  assign cnv_cmplt = cnv_q;
  assign lft_ld    = res_q[SLOT_LFT];
  assign rght_ld   = res_q[SLOT_RGHT];
  assign steer_pot = res_q[SLOT_STEER];
  assign batt      = res_q[SLOT_BATT];

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Self-checking bench for a2d_rr_sched: SPI stub, directed scenarios and randomized conversions.
module tb_a2d_rr_sched;

  localparam int unsigned GAP_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        wrt, done, busy, cnv_cmplt;
  logic [15:0] cmd, rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  logic        stub_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] stub_data = '0;
  logic [15:0] stray_data = '0;
  logic [15:0] stub_resp = '0;

  assign done    = stub_done | stray_done;
  assign rd_data = stray_done ? stray_data : stub_data;

  always #5 clk = ~clk;

  a2d_rr_sched #(
    .CH_LFT  (3'd0),
    .CH_RGHT (3'd4),
    .CH_STEER(3'd5),
    .CH_BATT (3'd6),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nxt      (nxt),
    .wrt      (wrt),
    .cmd      (cmd),
    .done     (done),
    .rd_data  (rd_data),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .steer_pot(steer_pot),
    .batt     (batt),
    .busy     (busy),
    .cnv_cmplt(cnv_cmplt)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- cycle counter and monitors ----------------
  int cyc = 0;
  int cnv_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (cnv_cmplt === 1'b1) cnv_cnt++;

  // ---------------- SPI stub ----------------
  int          stub_lat = 10;
  int          lat_left = 0;
  bit          outstanding = 0;
  bit          phase = 0;
  bit          stray_gap_en = 0;
  bit          gap_stray_now = 0;
  int          last_done_cyc = 0;
  int          overlap = 0;
  int          cmd_drift = 0;
  logic [15:0] txn_cmd = '0;
  logic [15:0] wrt_cmds [$];
  int          wrt_cyc [$];
  int          wrt_gap [$];

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (!rst_n) begin
      outstanding   = 0;
      phase         = 0;
      gap_stray_now = 0;
    end else begin
      if (gap_stray_now) begin
        stub_done     = 1'b1;
        stub_data     = 16'hFFFF;
        gap_stray_now = 0;
      end
      if (outstanding) begin
        if (lat_left == 0) begin
          stub_done   = 1'b1;
          outstanding = 0;
          if (cmd !== txn_cmd) cmd_drift++;
          if (!phase) begin
            stub_data     = 16'($urandom);
            last_done_cyc = cyc;
            if (stray_gap_en) gap_stray_now = 1;
          end else begin
            stub_data = stub_resp;
          end
          phase = !phase;
        end else begin
          lat_left--;
        end
      end
      if (wrt === 1'b1) begin
        if (outstanding) overlap++;
        wrt_cmds.push_back(cmd);
        wrt_cyc.push_back(cyc);
        wrt_gap.push_back(cyc - last_done_cyc - 1);
        outstanding = 1;
        lat_left    = stub_lat;
        txn_cmd     = cmd;
      end
    end
  end

  // ---------------- reference model ----------------
  int unsigned exp_reg [4];
  bit          seeded [4];
  int unsigned rr;
  int unsigned chan_tab [4] = '{0, 4, 5, 6};

  function automatic int unsigned exp_cmd(input int unsigned slot);
    return chan_tab[slot % 4] * 2048;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_reg[i] = 0;
      seeded[i]  = 0;
    end
    rr = 0;
  endtask

  task automatic model_conv(input int unsigned raw);
`ifdef A2D_AVG_EN
    if (seeded[rr]) exp_reg[rr] = (exp_reg[rr] + raw) / 2;
    else            exp_reg[rr] = raw;
    seeded[rr] = 1;
`else
    exp_reg[rr] = raw;
`endif
    rr = (rr + 1) % 4;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " lft_ld"},    32'(lft_ld),    exp_reg[0]);
    check({tag, " rght_ld"},   32'(rght_ld),   exp_reg[1]);
    check({tag, " steer_pot"}, 32'(steer_pot), exp_reg[2]);
    check({tag, " batt"},      32'(batt),      exp_reg[3]);
  endtask

  task automatic wait_cnv(output bit got);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cnv_cmplt === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [11:0] sample, input string tag);
    int          w0, c0, nc;
    int unsigned ec;
    bit          got;
    stub_resp = {4'($urandom), sample};
    w0 = wrt_cmds.size();
    c0 = cnv_cnt;
    ec = exp_cmd(rr);
    @(negedge clk);
    nxt = 1'b1;
    nc  = cyc;
    @(negedge clk);
    nxt = 1'b0;
    wait_cnv(got);
    check({tag, " completes"}, 32'(got), 32'd1);
    if (got) model_conv(32'(sample));
    check_regs(tag);
    check({tag, " busy clear"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " wrt count"}, 32'(wrt_cmds.size() - w0), 32'd2);
    if (wrt_cmds.size() >= w0 + 2) begin
      check({tag, " cmd first"},  32'(wrt_cmds[w0]),     ec);
      check({tag, " cmd second"}, 32'(wrt_cmds[w0 + 1]), ec);
      check({tag, " nxt->wrt"},   32'(wrt_cyc[w0] - nc), 32'd1);
      check({tag, " gap"},        32'(wrt_gap[w0 + 1]),  GAP_CYC);
    end
    check({tag, " cnv pulses"}, 32'(cnv_cnt - c0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int          w0, c0, c1;
    int unsigned e0, e1;
    bit          got;
    logic [11:0] s1, s2;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst wrt",  32'(wrt),       32'd0);
    check("rst busy", 32'(busy),      32'd0);
    check("rst cnv",  32'(cnv_cmplt), 32'd0);
    check("rst cmd",  32'(cmd),       32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion, upper rd_data bits must be discarded.
    stub_lat = 10;
    run_conv(12'hABC, "single");

    // Reset while waiting out the gap.
    stub_resp = 16'h0555;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("gap reached", 32'(got), 32'd1);
    @(negedge clk);
    check("gap busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst wrt",  32'(wrt),  32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst cmd",  32'(cmd),  32'd0);
    model_reset();
    check_regs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full rotation with fixed samples.
    run_conv(12'h111, "rot0");
    repeat (20) @(negedge clk);
    run_conv(12'h222, "rot1");
    repeat (20) @(negedge clk);
    run_conv(12'h333, "rot2");
    repeat (20) @(negedge clk);
    run_conv(12'h444, "rot3");
    repeat (20) @(negedge clk);

    // Extra requests during a busy conversion collapse into one follow-on.
    s1 = 12'($urandom);
    s2 = 12'($urandom);
    stub_resp = {4'($urandom), s1};
    w0 = wrt_cmds.size();
    c0 = cnv_cnt;
    e0 = exp_cmd(rr);
    e1 = exp_cmd(rr + 1);
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
    end
    wait_cnv(got);
    check("pend first completes", 32'(got), 32'd1);
    c1 = cyc;
    if (got) model_conv(32'(s1));
    check_regs("pend first");
    stub_resp = {4'($urandom), s2};
    wait_cnv(got);
    check("pend follow completes", 32'(got), 32'd1);
    if (got) model_conv(32'(s2));
    check_regs("pend follow");
    repeat (60) @(negedge clk);
    check("pend wrt count", 32'(wrt_cmds.size() - w0), 32'd4);
    check("pend cnv pulses", 32'(cnv_cnt - c0), 32'd2);
    if (wrt_cmds.size() >= w0 + 4) begin
      check("pend cmd first",  32'(wrt_cmds[w0]),     e0);
      check("pend cmd follow", 32'(wrt_cmds[w0 + 2]), e1);
      check("pend cmd read",   32'(wrt_cmds[w0 + 3]), e1);
      check("pend restart",    32'(wrt_cyc[w0 + 2] - c1), 32'd1);
    end

    // Stray done while idle.
    w0 = wrt_cmds.size();
    c0 = cnv_cnt;
    @(negedge clk);
    stray_done = 1'b1;
    stray_data = 16'hFFFF;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (8) @(negedge clk);
    check("stray idle wrt",  32'(wrt_cmds.size() - w0), 32'd0);
    check("stray idle cnv",  32'(cnv_cnt - c0), 32'd0);
    check("stray idle busy", 32'(busy), 32'd0);
    check_regs("stray idle");

    // Stray done during the gap.
    stray_gap_en = 1;
    run_conv(12'($urandom), "stray gap");
    stray_gap_en = 0;

    // Randomized conversions with varying link latency and spacing.
    for (int n = 0; n < 12; n++) begin
      stub_lat = int'($urandom_range(0, 12));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      run_conv(12'($urandom), "rand");
    end
    stub_lat = 10;

    // Averaging behaviour on the left channel from a fresh reset.
    do_reset();
    repeat (2) @(negedge clk);
    run_conv(12'h100, "avg a");
    check("avg first lft", 32'(lft_ld), 32'h100);
    run_conv(12'($urandom), "avg r");
    run_conv(12'($urandom), "avg s");
    run_conv(12'($urandom), "avg b");
    run_conv(12'h300, "avg c");
`ifdef A2D_AVG_EN
    check("avg second lft", 32'(lft_ld), 32'h200);
`else
    check("avg second lft", 32'(lft_ld), 32'h300);
`endif

    check("wrt overlap", 32'(overlap), 32'd0);
    check("cmd drift",   32'(cmd_drift), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
